// File: rtl/systolic_symmetric_fir_p.sv
// ---------------------------------------------------------------------------
// systolic_symmetric_fir_p
//
// Even-symmetric FIR filter of length 2*TAPS with double-buffered
// coefficients. Each accepted sample is folded against its mirror sample,
// multiplied by the active-bank coefficient and summed in a registered adder
// tree at full precision. The result is then delayed so that every result
// leaves exactly TAPS+4 cycles after its sample. The sum is rounded half up,
// arithmetically shifted and saturated to OUT_W bits.
//
// Ports
//   Clk_i         clock, all logic on the rising edge
//   Rst_i         synchronous active-high reset
//   Data_i        signed input sample (DATA_W)
//   DataNd_i      Data_i carries a new sample this cycle
//   CoefWe_i      write CoefData_i into the shadow bank at CoefAddr_i
//   CoefAddr_i    coefficient index k (writes with k >= TAPS are dropped)
//   CoefData_i    signed coefficient value (COEF_W)
//   CoefSwap_i    request to exchange the active and shadow banks
//   Data_o        filtered, rounded, saturated output (OUT_W)
//   DataValid_o   one-cycle strobe per accepted sample
//   Overflow_o    Data_o was clamped (qualified by DataValid_o)
//   ActiveBank_o  index of the bank used for newly accepted samples
// ---------------------------------------------------------------------------
module systolic_symmetric_fir_p #(
  parameter int DATA_W    = 18,
  parameter int COEF_W    = 18,
  parameter int TAPS      = 16,
  parameter int OUT_W     = 18,
  parameter int OUT_SHIFT = 17
) (
  input  logic                    Clk_i,
  input  logic                    Rst_i,
  input  logic [DATA_W-1:0]       Data_i,
  input  logic                    DataNd_i,
  input  logic                    CoefWe_i,
  input  logic [$clog2(TAPS)-1:0] CoefAddr_i,
  input  logic [COEF_W-1:0]       CoefData_i,
  input  logic                    CoefSwap_i,
  output logic [OUT_W-1:0]        Data_o,
  output logic                    DataValid_o,
  output logic                    Overflow_o,
  output logic                    ActiveBank_o
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int LVLS   = $clog2(TAPS);
  localparam int LEAVES = 1 << LVLS;
  localparam int NODES  = 2 * LEAVES - 1;
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;
  localparam int ACC_W  = PROD_W + LVLS;
  localparam int HIST_N = 2 * TAPS - 1;
  // Stages: fold (1) + product (1) + tree (LVLS) + pad (PAD) + output (1)
  // add up to TAPS+4.
  localparam int PAD    = TAPS + 1 - LVLS;

  localparam logic [ACC_W:0]        ONE     = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] RND     = ONE << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ONE << (OUT_W - 1)) - ONE;
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  genvar gi;

  // -------------------------------------------------------------------------
  // Coefficient banks and bank selection
  // -------------------------------------------------------------------------
  logic signed [COEF_W-1:0] r_coef0 [TAPS];
  logic signed [COEF_W-1:0] r_coef1 [TAPS];
  logic                     r_bank;
  logic                     r_swap_d;
  logic                     w_addr_ok;
  logic                     w_swap_go;

  assign w_addr_ok = ({1'b0, CoefAddr_i} < (ADDR_W + 1)'(TAPS));
  // A held-high swap request toggles only once.
  assign w_swap_go = CoefSwap_i & ~r_swap_d;

  // Writes always target the bank that is not active in this cycle, so a
  // same-cycle write + swap lands in the bank that becomes active.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      for (int k = 0; k < TAPS; k++) begin
        r_coef0[k] <= '0;
        r_coef1[k] <= '0;
      end
    end else if (CoefWe_i && w_addr_ok) begin
      if (r_bank) begin
        r_coef0[CoefAddr_i] <= CoefData_i;
      end else begin
        r_coef1[CoefAddr_i] <= CoefData_i;
      end
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_bank   <= 1'b0;
      r_swap_d <= 1'b0;
    end else begin
      r_bank   <= r_bank ^ w_swap_go;
      r_swap_d <= CoefSwap_i;
    end
  end

  // -------------------------------------------------------------------------
  // Sample history: r_hist[j] holds x[n-1-j] relative to the incoming sample
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] r_hist [HIST_N];

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      for (int j = 0; j < HIST_N; j++) begin
        r_hist[j] <= '0;
      end
    end else if (DataNd_i) begin
      r_hist[0] <= Data_i;
      for (int j = 1; j < HIST_N; j++) begin
        r_hist[j] <= r_hist[j-1];
      end
    end
  end

  // Fold: pre[k] = x[n-k] + x[n-(2*TAPS-1-k)], with x[n] = Data_i.
  logic signed [PRE_W-1:0] w_pre [TAPS];

  for (gi = 0; gi < TAPS; gi++) begin : g_fold
    logic [DATA_W-1:0] w_near;
    logic [DATA_W-1:0] w_far;
    if (gi == 0) begin : g_newest
      assign w_near = Data_i;
    end else begin : g_older
      assign w_near = r_hist[gi-1];
    end
    assign w_far     = r_hist[HIST_N-1-gi];
    assign w_pre[gi] = {w_near[DATA_W-1], w_near} + {w_far[DATA_W-1], w_far};
  end

  // -------------------------------------------------------------------------
  // Stage 1: capture folded samples and the bank that owns this sample
  // -------------------------------------------------------------------------
  logic signed [PRE_W-1:0] r_pre [TAPS];
  logic                    r_sel;
  logic                    r_v1;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_v1  <= 1'b0;
      r_sel <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        r_pre[k] <= '0;
      end
    end else begin
      r_v1 <= DataNd_i;
      if (DataNd_i) begin
        r_sel <= r_bank;
        for (int k = 0; k < TAPS; k++) begin
          r_pre[k] <= w_pre[k];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: products. The bank owned by this sample can only be rewritten
  // from this cycle on, and such a write lands after the product is taken,
  // so every product of one sample comes from a single, unmodified bank.
  // Leaves beyond TAPS are zero so the tree can be a full binary tree.
  // -------------------------------------------------------------------------
  logic signed [PROD_W-1:0] w_prod [LEAVES];

  for (gi = 0; gi < LEAVES; gi++) begin : g_mult
    if (gi < TAPS) begin : g_tap
      logic signed [COEF_W-1:0] w_coef;
      assign w_coef     = r_sel ? r_coef1[gi] : r_coef0[gi];
      assign w_prod[gi] = r_pre[gi] * w_coef;
    end else begin : g_zero
      assign w_prod[gi] = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Registered adder tree stored as a heap: node i sums nodes 2i+1 and 2i+2,
  // leaves occupy LEAVES-1 .. NODES-1, the root (node 0) is LVLS cycles
  // behind the leaves. Full precision throughout.
  // -------------------------------------------------------------------------
  logic signed [ACC_W-1:0] r_node [NODES];
  logic [LVLS:0]           r_tv;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_tv <= '0;
      for (int i = 0; i < NODES; i++) begin
        r_node[i] <= '0;
      end
    end else begin
      r_tv <= {r_tv[LVLS-1:0], r_v1};
      for (int i = 0; i < LEAVES - 1; i++) begin
        r_node[i] <= r_node[2*i+1] + r_node[2*i+2];
      end
      for (int i = 0; i < LEAVES; i++) begin
        r_node[LEAVES-1+i] <= ACC_W'(w_prod[i]);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Delay line bringing the total latency to TAPS+4
  // -------------------------------------------------------------------------
  logic signed [ACC_W-1:0] r_pd_acc [PAD];
  logic [PAD-1:0]          r_pd_vld;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_pd_vld <= '0;
      for (int i = 0; i < PAD; i++) begin
        r_pd_acc[i] <= '0;
      end
    end else begin
      r_pd_vld    <= {r_pd_vld[PAD-2:0], r_tv[LVLS]};
      r_pd_acc[0] <= r_node[0];
      for (int i = 1; i < PAD; i++) begin
        r_pd_acc[i] <= r_pd_acc[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Round half up, arithmetic shift, saturate
  // -------------------------------------------------------------------------
  logic signed [ACC_W:0] w_rounded;
  logic signed [ACC_W:0] w_shifted;
  logic                  w_pos_sat;
  logic                  w_neg_sat;

  // One guard bit so adding the rounding constant cannot wrap.
  assign w_rounded = {r_pd_acc[PAD-1][ACC_W-1], r_pd_acc[PAD-1]} + RND;
  assign w_shifted = w_rounded >>> OUT_SHIFT;
  assign w_pos_sat = (w_shifted > SAT_MAX);
  assign w_neg_sat = (w_shifted < SAT_MIN);

  logic [OUT_W-1:0] r_data;
  logic             r_valid;
  logic             r_ovf;

  // Data and overflow only move with a valid result and hold otherwise.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= r_pd_vld[PAD-1];
      if (r_pd_vld[PAD-1]) begin
        r_ovf <= w_pos_sat | w_neg_sat;
        if (w_pos_sat) begin
          r_data <= SAT_MAX[OUT_W-1:0];
        end else if (w_neg_sat) begin
          r_data <= SAT_MIN[OUT_W-1:0];
        end else begin
          r_data <= w_shifted[OUT_W-1:0];
        end
      end
    end
  end

  assign Data_o       = r_data;
  assign DataValid_o  = r_valid;
  assign Overflow_o   = r_ovf;
  assign ActiveBank_o = r_bank;

endmodule

// File: tb/tb_systolic_symmetric_fir_p.sv
// ---------------------------------------------------------------------------
// tb_systolic_symmetric_fir_p
//
// Directed bench for systolic_symmetric_fir_p with TAPS=4, OUT_SHIFT=1.
// Each accepted sample queues a hand-computed expected output; a monitor on
// the falling edge pairs every DataValid_o with the oldest queued entry and
// checks value, overflow flag and the exact 8-cycle latency, and checks that
// Data_o / Overflow_o hold between valids.
// ---------------------------------------------------------------------------
module tb_systolic_symmetric_fir_p;

  localparam int DATA_W    = 18;
  localparam int COEF_W    = 18;
  localparam int TAPS      = 4;
  localparam int OUT_W     = 18;
  localparam int OUT_SHIFT = 1;
  localparam int LAT       = TAPS + 4;
  localparam int PMAX      = 131071;
  localparam int NMIN      = -131072;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data_i;
  logic              data_nd;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              coef_swap;
  logic [OUT_W-1:0]  data_o;
  logic              data_valid;
  logic              overflow;
  logic              active_bank;

  systolic_symmetric_fir_p #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .TAPS      (TAPS),
    .OUT_W     (OUT_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) dut (
    .Clk_i        (clk),
    .Rst_i        (rst),
    .Data_i       (data_i),
    .DataNd_i     (data_nd),
    .CoefWe_i     (coef_we),
    .CoefAddr_i   (coef_addr),
    .CoefData_i   (coef_data),
    .CoefSwap_i   (coef_swap),
    .Data_o       (data_o),
    .DataValid_o  (data_valid),
    .Overflow_o   (overflow),
    .ActiveBank_o (active_bank)
  );

  typedef struct {
    logic signed [17:0] v;
    logic               o;
    bit                 chk;
  } exp_t;

  exp_t q_exp[$];
  int   q_due[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   k_neg    = 0;
  logic signed [63:0] last_d = 0;
  logic               last_o = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    int   due;
    k_neg++;
    if (rst) begin
      q_due.delete();
      q_exp.delete();
      last_d = 0;
      last_o = 0;
    end else begin
      if (data_valid) begin
        $display("out t=%0d data=%0d ovf=%0d", k_neg, $signed(data_o), overflow);
        if (q_due.size() == 0 || q_exp.size() == 0) begin
          check_eq("spurious_valid", data_valid, 0);
        end else begin
          due = q_due.pop_front();
          e   = q_exp.pop_front();
          check_eq("latency", k_neg, due);
          if (e.chk) begin
            check_eq("data", $signed(data_o), e.v);
            check_eq("ovf", overflow, e.o);
          end
        end
        last_d = $signed(data_o);
        last_o = overflow;
      end else begin
        if (q_due.size() > 0 && q_due[0] <= k_neg) begin
          check_eq("missing_valid", data_valid, 1);
          void'(q_due.pop_front());
          if (q_exp.size() > 0) void'(q_exp.pop_front());
        end
        check_eq("hold_data", $signed(data_o), last_d);
        check_eq("hold_ovf", overflow, last_o);
      end
      if (data_nd) q_due.push_back(k_neg + LAT);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wr(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = a[1:0];
    coef_data = v[17:0];
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic swap();
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
  endtask

  // Drive one sample; queue its expected output unless reset is active.
  task automatic smp(input int x, input int ev, input bit eo, input bit chk,
                     input bit swp);
    exp_t e;
    data_i    = x[17:0];
    data_nd   = 1'b1;
    coef_swap = swp;
    if (!rst) begin
      e.v   = ev[17:0];
      e.o   = eo;
      e.chk = chk;
      q_exp.push_back(e);
    end
    tick();
    data_nd   = 1'b0;
    coef_swap = 1'b0;
  endtask

  function automatic int chirp(input int i);
    return ((i * i * 7) % 2000) - 1000;
  endfunction

  int imp_exp[12] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 0, 0};
  int ws_exp[9]   = '{3, 0, 0, 0, 0, 0, 0, 3, 0};
  int c_imp[4]    = '{2, 4, 6, 8};

  initial begin
    rst       = 1'b1;
    data_i    = '0;
    data_nd   = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    coef_swap = 1'b0;
    idle(3);
    rst = 1'b0;

    // Reset state
    check_eq("rst_data", $signed(data_o), 0);
    check_eq("rst_valid", data_valid, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_bank", active_bank, 0);

    // Impulse response, back-to-back samples
    for (int k = 0; k < 4; k++) wr(k, c_imp[k]);
    check_eq("bank_before_swap", active_bank, 0);
    swap();
    check_eq("bank_after_swap", active_bank, 1);
    for (int i = 0; i < 12; i++) smp((i == 0) ? 1 : 0, imp_exp[i], 1'b0, 1'b1, 1'b0);
    idle(LAT + 2);

    // Same impulse with a sample every third cycle
    for (int i = 0; i < 12; i++) begin
      smp((i == 0) ? 1 : 0, imp_exp[i], 1'b0, 1'b1, 1'b0);
      idle(2);
    end
    idle(LAT + 2);

    // Mid-stream swap: bank0 all 2, bank1 all 4, DC input of 1
    reset_dut(1);
    for (int k = 0; k < 4; k++) wr(k, 2);
    swap();
    for (int k = 0; k < 4; k++) wr(k, 2);
    swap();
    check_eq("bank0_active", active_bank, 0);
    for (int k = 0; k < 4; k++) wr(k, 4);
    for (int i = 0; i < 10; i++) smp(1, (i < 8) ? i + 1 : 8, 1'b0, 1'b1, 1'b0);
    smp(1, 8, 1'b0, 1'b1, 1'b1);
    check_eq("bank_toggle_midstream", active_bank, 1);
    for (int i = 0; i < 6; i++) smp(1, 16, 1'b0, 1'b1, 1'b0);
    idle(LAT + 2);

    // A swap request held high for two cycles toggles once
    coef_swap = 1'b1;
    tick();
    check_eq("held_swap_first", active_bank, 0);
    tick();
    check_eq("held_swap_second", active_bank, 0);
    coef_swap = 1'b0;
    tick();
    check_eq("held_swap_after", active_bank, 0);

    // Saturation in both directions
    reset_dut(1);
    for (int k = 0; k < 4; k++) wr(k, PMAX);
    swap();
    for (int i = 0; i < 10; i++) smp(PMAX, PMAX, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) smp(NMIN, (i < 3) ? PMAX : NMIN, 1'b1, 1'b1, 1'b0);
    idle(LAT + 2);

    // Reset pulse during a continuous chirp
    reset_dut(1);
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    swap();
    for (int i = 0; i < 12; i++) smp(chirp(i), 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    smp(chirp(12), 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check_eq("bank_after_midreset", active_bank, 0);
    check_eq("valid_after_midreset", data_valid, 0);
    for (int i = 13; i < 25; i++) smp(chirp(i), 0, 1'b0, 1'b1, 1'b0);
    idle(LAT + 2);

    // Simultaneous write and swap: the written value becomes active
    reset_dut(2);
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 18'd5;
    coef_swap = 1'b1;
    tick();
    coef_we   = 1'b0;
    coef_swap = 1'b0;
    check_eq("bank_write_swap", active_bank, 1);
    for (int i = 0; i < 9; i++) smp((i == 0) ? 1 : 0, ws_exp[i], 1'b0, 1'b1, 1'b0);

    // Drain with a bounded wait
    for (int i = 0; i < 4 * LAT && q_due.size() > 0; i++) tick();
    idle(2);
    check_eq("drain_pending", q_due.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/systolic_symmetric_fir_p.md
SYSTOLIC_SYMMETRIC_FIR_P -- requirements
Module: systolic_symmetric_fir_p

Interface
REQ-001 SHALL have parameter DATA_W, default 18, meaning signed input sample width.
REQ-002 SHALL have parameter COEF_W, default 18, meaning signed coefficient width.
REQ-003 SHALL have parameter TAPS, default 16, meaning number of unique coefficients; filter length is 2*TAPS, even-symmetric; legal range 2..64.
REQ-004 SHALL have parameter OUT_W, default 18, meaning signed output width.
REQ-005 SHALL have parameter OUT_SHIFT, default 17, meaning right shift applied to the full-precision sum; legal range 1..(DATA_W+COEF_W).
REQ-006 SHALL have port Clk_i, input, 1 bit, meaning single clock; all logic on rising edge.
REQ-007 SHALL have port Rst_i, input, 1 bit, meaning reset, synchronous, active-high.
REQ-008 SHALL have port Data_i, input, DATA_W bits, meaning signed sample.
REQ-009 SHALL have port DataNd_i, input, 1 bit, meaning Data_i is a new sample this cycle.
REQ-010 SHALL have port CoefWe_i, input, 1 bit, meaning write CoefData_i to the shadow bank at CoefAddr_i.
REQ-011 SHALL have port CoefAddr_i, input, clog2(TAPS) bits, meaning coefficient index k.
REQ-012 SHALL have port CoefData_i, input, COEF_W bits, meaning signed coefficient value.
REQ-013 SHALL have port CoefSwap_i, input, 1 bit, meaning a one-cycle request to exchange the active and shadow banks.
REQ-014 SHALL have port Data_o, output, OUT_W bits, meaning filtered sample.
REQ-015 SHALL have port DataValid_o, output, 1 bit, meaning Data_o is valid this cycle.
REQ-016 SHALL have port Overflow_o, output, 1 bit, meaning Data_o was saturated; qualified by DataValid_o.
REQ-017 SHALL have port ActiveBank_o, output, 1 bit, meaning index of the bank currently used for filtering.

Function
REQ-018 SHALL index accepted samples x[n] only on cycles with DataNd_i=1; cycles with DataNd_i=0 do not advance the sample history.
REQ-019 SHALL compute acc[n] = sum over k=0..TAPS-1 of c[k]*(x[n-k] + x[n-(2*TAPS-1-k)]) at full precision (DATA_W+1+COEF_W+clog2(TAPS) bits), with no intermediate truncation.
REQ-020 SHALL produce Data_o = saturate_OUT_W((acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT), i.e. round half up, then arithmetic shift.
REQ-021 SHALL clamp to +2^(OUT_W-1)-1 or -2^(OUT_W-1) on overflow, and assert Overflow_o in the same cycle as that output.
REQ-022 SHALL assert DataValid_o for exactly one cycle, exactly LAT = TAPS+4 cycles after each DataNd_i=1 cycle; one valid per accepted sample, in order.
REQ-023 SHALL sustain full throughput, with DataNd_i=1 on every cycle, and handle arbitrary gaps without changing results or latency.
REQ-024 SHALL hold Data_o and Overflow_o at their last values while DataValid_o=0.
REQ-025 SHALL write the shadow bank on CoefWe_i=1; the active bank is never written directly.
REQ-026 SHALL toggle ActiveBank_o in the cycle after CoefSwap_i=1.
REQ-027 SHALL filter every sample whose DataNd_i cycle is at or after that toggle cycle with the new bank in full, and every earlier sample with the old bank in full; no output mixes banks.
REQ-028 SHALL, when CoefWe_i and CoefSwap_i are both 1 in the same cycle, apply the write before the swap, so the written value becomes active.
REQ-029 SHALL ignore CoefWe_i when CoefAddr_i >= TAPS.
REQ-030 SHALL ignore CoefSwap_i pulses on consecutive cycles after the first until the swap has taken effect: one toggle per cycle maximum.

Reset
REQ-031 SHALL, while Rst_i=1: clear the sample history, both coefficient banks and all pipeline partial sums to 0; set Data_o=0, DataValid_o=0, Overflow_o=0 and ActiveBank_o=0.
REQ-032 SHALL, on Rst_i asserted mid-stream, discard all in-flight samples, so that no DataValid_o appears for samples accepted before or during reset.
REQ-033 SHALL, in the first cycle after Rst_i deasserts, accept DataNd_i normally, with history equal to zeros.

Verification
REQ-034 SHALL verify the impulse response: TAPS=4, OUT_SHIFT=1, load c={2,4,6,8} and swap, then one sample 1 followed by zeros -> outputs 1,2,3,4,4,3,2,1 then 0, each LAT=8 cycles after its sample.
REQ-035 SHALL verify saturation: all c=2^17-1, continuous x=2^17-1 -> Data_o=131071 with Overflow_o=1; x=-2^17 -> Data_o=-131072 with Overflow_o=1.
REQ-036 SHALL verify gapped input: the REQ-034 stimulus with DataNd_i high every 3rd cycle -> the same output sequence, each valid exactly 8 cycles after its sample.
REQ-037 SHALL verify a mid-stream swap: continuous DC 1, bank0 all c=2 and bank1 all c=4 (OUT_SHIFT=1) -> outputs step from 8 to 16 with no intermediate value, starting with the first sample at or after the ActiveBank_o toggle.
REQ-038 SHALL verify mid-stream reset: Rst_i high for 1 cycle during a continuous chirp -> DataValid_o stays 0 for LAT cycles, banks read 0 and outputs are 0 until new coefficients are loaded.
REQ-039 SHALL verify simultaneous write and swap: CoefWe_i (addr 0, 5) with CoefSwap_i in the same cycle -> the impulse response first output is 5>>>OUT_SHIFT with rounding.
